// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and constants for the writeback path.
package mips_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 1 << REG_W;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry;

endpackage

// File: rtl/wb_queue.sv
// Circular load-result FIFO with per-entry valid bits, a parallel dest-match
// squash port and a registered one-hot map of destinations still pending.
module wb_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  wb_entry             push_entry,
  input  logic                pop,
  input  logic                squash,
  input  logic [REG_W-1:0]    squash_dest,
  output wb_entry             head,
  output logic                empty,
  output logic                full,
  output logic [NUM_REGS-1:0] pending
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry             slots   [DEPTH];
  wb_entry             slots_n [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0]    wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]    count, count_n;
  logic [NUM_REGS-1:0] pending_n;
  logic                push_ok;
  logic                pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = slots[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Slots outside the live window always hold valid=0, so pending can be
  // decoded across every slot without masking by the pointers.
  always_comb begin
    slots_n  = slots;
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (squash && (slots[i].dest == squash_dest)) begin
        slots_n[i].valid = 1'b0;
      end
    end

    if (pop_ok) begin
      slots_n[rd_ptr].valid = 1'b0;
      rd_ptr_n              = rd_ptr + 1'b1;
    end

    if (push_ok) begin
      slots_n[wr_ptr] = push_entry;
      if (squash && (push_entry.dest == squash_dest)) begin
        slots_n[wr_ptr].valid = 1'b0;
      end
      wr_ptr_n = wr_ptr + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase

    pending_n = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slots_n[i].valid) begin
        pending_n[slots_n[i].dest] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      slots   <= slots_n;
      rd_ptr  <= rd_ptr_n;
      wr_ptr  <= wr_ptr_n;
      count   <= count_n;
      pending <= pending_n;
    end
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results have priority, queued load
// results are guaranteed a slot after STARVE_LIMIT consecutive ALU grants.
module reg_writeback_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [REG_W-1:0]    alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [REG_W-1:0]    mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic [REG_W-1:0]    write_register,
  output logic [DATA_W-1:0]   write_data,
  output logic                write_switch,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    drop_count
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  wb_entry             q_head;
  wb_entry             q_push_entry;
  logic                q_empty;
  logic                q_full;
  logic                q_push;
  logic                q_pop;
  logic [NUM_REGS-1:0] q_pending;

  logic [STARVE_W-1:0] starve, starve_n;
  logic                head_live;
  logic                head_dead;
  logic                stall;
  logic                alu_take;
  logic                alu_grant;
  logic                alu_drop;
  logic                mem_take;
  logic                mem_drop;
  logic                mem_grant;
  logic [1:0]          drop_inc;
  logic [CNT_W:0]      drop_sum;

  assign head_live = !q_empty && q_head.valid;
  assign head_dead = !q_empty && !q_head.valid;
  assign stall     = head_live && (starve == STARVE_MAX);

  assign alu_ready = !stall;
  assign alu_take  = alu_valid && !stall;
  assign alu_grant = alu_take && (alu_dest != REG_ZERO);
  assign alu_drop  = alu_take && (alu_dest == REG_ZERO);

  assign mem_ready = !q_full;
  assign mem_take  = mem_valid && !q_full;
  assign mem_drop  = mem_take && (mem_dest == REG_ZERO);

  // A squashed head is retired alongside whatever else wins this cycle; it
  // never lets the entry behind it reach the write port in the same cycle.
  assign mem_grant = head_live && (stall || !alu_grant);
  assign q_pop     = mem_grant || head_dead;
  assign q_push    = mem_take && (mem_dest != REG_ZERO);

  assign q_push_entry = '{valid: 1'b1, dest: mem_dest, data: mem_data};

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push        (q_push),
    .push_entry  (q_push_entry),
    .pop         (q_pop),
    .squash      (alu_grant),
    .squash_dest (alu_dest),
    .head        (q_head),
    .empty       (q_empty),
    .full        (q_full),
    .pending     (q_pending)
  );

  assign pending = q_pending;

  // Any head retirement restarts the wait; the new head has only just arrived.
  always_comb begin
    starve_n = starve;
    if (q_empty || mem_grant || head_dead) begin
      starve_n = '0;
    end else if (alu_grant && (starve != STARVE_MAX)) begin
      starve_n = starve + 1'b1;
    end
  end

  assign drop_inc = {1'b0, alu_drop} + {1'b0, mem_drop};
  assign drop_sum = {1'b0, drop_count} + (CNT_W + 1)'(drop_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve         <= '0;
      write_switch   <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      drop_count     <= '0;
    end else begin
      starve <= starve_n;

      if (alu_grant) begin
        write_switch   <= 1'b1;
        write_register <= alu_dest;
        write_data     <= alu_data;
      end else if (mem_grant) begin
        write_switch   <= 1'b1;
        write_register <= q_head.dest;
        write_data     <= q_head.data;
      end else begin
        write_switch   <= 1'b0;
      end

      if (drop_sum[CNT_W]) begin
        drop_count <= '1;
      end else begin
        drop_count <= drop_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Scoreboard bench for reg_writeback_arbiter: directed vectors queue the
// expected register-file writes, a negedge monitor retires them in order.
module tb_reg_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_switch;
  logic [31:0] pending;
  logic [7:0]  drop_count;

  int checks = 0;
  int passes = 0;

  logic [36:0] exp_q [$];

  reg_writeback_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4),
    .CNT_W        (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_dest       (alu_dest),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_dest       (mem_dest),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
    .write_register (write_register),
    .write_data     (write_data),
    .write_switch   (write_switch),
    .pending        (pending),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                       input logic mv, input logic [4:0] md, input logic [31:0] mdat);
    @(negedge clk);
    alu_valid = av;
    alu_dest  = ad;
    alu_data  = adat;
    mem_valid = mv;
    mem_dest  = md;
    mem_data  = mdat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Monitor: every observed write must match the oldest expected write.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (!reset && write_switch) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {27'd0, write_register}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("write_register", {27'd0, write_register}, {27'd0, e[36:32]});
          check("write_data", write_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    int k;
    int stalls;
    int stall_cyc;

    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_dest  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_dest  = '0;
    mem_data  = '0;
    #1;
    check("rst_write_switch", {31'd0, write_switch}, 32'd0);
    check("rst_write_register", {27'd0, write_register}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);
    check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // ALU only
    expect_write(5'd5, 32'hDEADBEEF);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    idle();
    idle();
    check("alu_single_cycle_pulse", {31'd0, write_switch}, 32'd0);

    // Load only
    expect_write(5'd9, 32'h0000_1234);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_1234);
    check("load_mem_ready", {31'd0, mem_ready}, 32'd1);
    idle();
    check("load_pending_set", pending, 32'h0000_0200);
    idle();
    check("load_pending_clear", pending, 32'd0);

    // Starvation: load to r3 waits behind a continuous r7 ALU stream
    for (int i = 0; i < 5; i++) expect_write(5'd7, 32'h70 + i);
    expect_write(5'd3, 32'h33);
    expect_write(5'd7, 32'h75);
    expect_write(5'd7, 32'h76);
    k = 0;
    stalls = 0;
    stall_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 5'd7, 32'h70 + k, (c == 0), 5'd3, 32'h33);
      if (alu_ready) begin
        k++;
      end else begin
        stalls++;
        stall_cyc = c;
      end
    end
    idle();
    check("starve_stall_count", stalls, 32'd1);
    check("starve_stall_cycle", stall_cyc, 32'd5);
    check("starve_alu_accepted", k, 32'd7);
    check("starve_queue_drained", pending, 32'd0);

    // Squash of a queued load by a younger ALU write
    expect_write(5'd20, 32'h2000);
    expect_write(5'd12, 32'hBBBB);
    drive(1'b1, 5'd20, 32'h2000, 1'b1, 5'd12, 32'hAAAA);
    drive(1'b1, 5'd12, 32'hBBBB, 1'b0, 5'd0, 32'h0);
    check("squash_pending_before", pending, 32'h0000_1000);
    idle();
    check("squash_pending_after", pending, 32'd0);
    idle();
    idle();
    check("squash_silent_pop", {31'd0, write_switch}, 32'd0);

    // Load arriving alongside an ALU write to the same register
    expect_write(5'd15, 32'h1515);
    drive(1'b1, 5'd15, 32'h1515, 1'b1, 5'd15, 32'h5151);
    idle();
    check("squash_on_entry_pending", pending, 32'd0);
    idle();
    idle();

    // Backpressure with DEPTH=2
    expect_write(5'd21, 32'h21);
    expect_write(5'd23, 32'h23);
    expect_write(5'd25, 32'h25);
    expect_write(5'd22, 32'h22);
    expect_write(5'd24, 32'h24);
    drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22);
    drive(1'b1, 5'd23, 32'h23, 1'b1, 5'd24, 32'h24);
    check("bp_mem_ready_one_free", {31'd0, mem_ready}, 32'd1);
    drive(1'b1, 5'd25, 32'h25, 1'b0, 5'd0, 32'h0);
    check("bp_mem_ready_full", {31'd0, mem_ready}, 32'd0);
    check("bp_pending_full", pending, 32'h0140_0000);
    idle();
    idle();
    idle();

    // $0 drops from both sources together, then saturation
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    check("zero_alu_ready", {31'd0, alu_ready}, 32'd1);
    check("zero_mem_ready", {31'd0, mem_ready}, 32'd1);
    idle();
    check("zero_drop_plus2", {24'd0, drop_count}, 32'd2);
    check("zero_no_write", {31'd0, write_switch}, 32'd0);
    repeat (130) drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
    idle();
    check("drop_saturate", {24'd0, drop_count}, 32'd255);

    // Async reset with a full queue
    expect_write(5'd1, 32'h101);
    expect_write(5'd1, 32'h102);
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202);
    drive(1'b1, 5'd1, 32'h102, 1'b1, 5'd4, 32'h404);
    idle();
    check("rst2_full_before", {31'd0, mem_ready}, 32'd0);
    check("rst2_pending_before", pending, 32'h0000_0014);
    #2;
    reset = 1'b1;
    #1;
    check("rst2_write_switch", {31'd0, write_switch}, 32'd0);
    check("rst2_write_register", {27'd0, write_register}, 32'd0);
    check("rst2_write_data", write_data, 32'd0);
    check("rst2_pending", pending, 32'd0);
    check("rst2_drop_count", {24'd0, drop_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
    idle();
    check("rst2_mem_ready_after", {31'd0, mem_ready}, 32'd1);
    check("rst2_no_write_after", {31'd0, write_switch}, 32'd0);
    check("rst2_pending_after", pending, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Write-side initiator for the 32x32 MIPS register file.
- Merges two result sources onto the file's single write port (write_register / write_data / write_switch): the single-cycle ALU path and the variable-latency load path.
- Load results are buffered in a small queue. The ALU has priority, with a bounded-starvation guarantee for loads.
- Never issues a write to $0. Squashes queued load results made stale by a newer ALU write to the same register.

Parameters:
- DEPTH, 2, load-queue entries (power of 2, 2..8).
- STARVE_LIMIT, 4, cycles a non-empty queue may wait before the ALU is stalled for one cycle.
- CNT_W, 8, width of the dropped-write counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- alu_valid  in  1  ALU result present this cycle.
- alu_dest  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU result accepted this cycle; ALU holds when low.
- mem_valid  in  1  load result offered.
- mem_dest  in  5  load destination register.
- mem_data  in  32  load data.
- mem_ready  out  1  queue can accept; a transfer occurs when mem_valid && mem_ready.
- write_register  out  5  to register file.
- write_data  out  32  to register file.
- write_switch  out  1  register-file write enable.
- pending  out  32  bit r set while a queued, un-squashed load targets r (hazard unit reads this).
- drop_count  out  CNT_W  saturating count of writes discarded for dest==$0.

Behaviour:
- Reset: queue empty, starve counter 0, write_switch=0, write_register=0, write_data=0, pending=0, drop_count=0, alu_ready=1, mem_ready=1. Reset mid-operation discards queued entries; no write is issued in the cycle reset deasserts.
- Outputs are registered. A source selected in cycle N appears on write_* in cycle N+1 with write_switch=1 for exactly one cycle. The register file samples on the falling edge, so the outputs are stable half a cycle before capture.
- mem_ready = queue not full (combinational from registered count). A push with mem_dest==0 is not queued: drop_count increments and the handshake still completes.
- alu_valid with alu_dest==0: consumed (alu_ready=1), drop_count increments, no write issued.
- When both drops coincide, drop_count increments by 2, saturating at all-ones.
- Arbitration per cycle:
  - (a) STALL: if queue non-empty and starve counter == STARVE_LIMIT, then alu_ready=0, the queue head is written, and starve counter resets to 0.
  - (b) otherwise, if alu_valid and alu_dest!=0, then the ALU is written, alu_ready=1, and starve counter increments if the queue is non-empty.
  - (c) otherwise, if the queue is non-empty, pop the head and write it; starve counter resets to 0.
  - (d) otherwise, write_switch=0 next cycle.
- Starve counter holds 0 while the queue is empty.
- Squash: when an ALU write to register r is granted, every queued entry with dest r becomes invalid. A load arriving in the same cycle with mem_dest==r is older in program order and is also squashed on entry.
- An invalid head is popped without a write (write_switch=0); pop and write proceed only for valid heads. A squashed pop does not consume an arbitration slot: valid head+1 is not promoted the same cycle.
- pending is recomputed from valid queue entries and is registered (same cycle as queue state).
- Simultaneous push and pop when full: mem_ready is still 0 (no same-cycle bypass of full).
- Ordering between queued loads is FIFO.

Decomposition:
- Shared package mips_pkg: REG_W=5, DATA_W=32, REG_ZERO=5'd0, and the wb_entry struct {valid, dest, data}.
- One natural sub-module: wb_queue (parameterised circular FIFO with per-entry valid bit and parallel dest-match squash input).
- Arbiter and counters stay in the top.

Test Plan:
- ALU only: alu_valid, dest=5, data=0xDEADBEEF at cycle 1 -> cycle 2 write_switch=1, write_register=5, write_data=0xDEADBEEF; cycle 3 write_switch=0.
- Load only: mem push dest=9 data=0x1234 with ALU idle -> pending[9]=1 next cycle; write of reg 9 follows; pending[9]=0 after pop.
- Starvation: queue holds dest=3 and ALU valid every cycle (dest 7) -> after 4 ALU grants alu_ready=0 for one cycle, reg 3 written, ALU resumes; ALU data never lost.
- Squash: queue dest=12 data=0xAAAA, then ALU dest=12 data=0xBBBB granted -> pending[12] clears; only one write to reg 12 (0xBBBB); squashed entry pops silently.
- $0 and backpressure: DEPTH=2 filled while ALU busy -> mem_ready=0; ALU dest=0 and mem dest=0 in the same cycle -> no write, drop_count +2.
- Async reset asserted mid-stream with queue full -> all outputs zero immediately; queue empty; mem_ready=1 after release.
